// File: rtl/port_out_uart_tx_if.sv
// CPU-side port bundle for the output-port UART: byte/strobe in, serial line and status out.
interface port_out_uart_tx_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    // port_we is a one-cycle strobe with no ready: a byte is taken on the edge
    // where port_we=1 and full=0, otherwise it is dropped and overflow latches.
    logic [7:0]    port_out;
    logic          port_we;
    logic          tx;
    logic          busy;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;

    modport master (
        output port_out, port_we,
        input  tx, busy, full, empty, count, overflow
    );

    modport slave (
        input  port_out, port_we,
        output tx, busy, full, empty, count, overflow
    );
endinterface

// File: rtl/port_out_uart_tx.sv
// Buffers cpu port_out writes in a small FIFO and streams them as 8N1 frames on tx.
module port_out_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    port_out_uart_tx_if.slave    bus,
    output logic [1:0]           dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shift, shift_n;
    logic          tx_r, tx_n;
    logic          pop;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_r;
    logic          overflow_r;

    logic full_w, empty_w, wr_en, baud_done;

    assign full_w    = (count_r == CW'(DEPTH));
    assign empty_w   = (count_r == '0);
    assign wr_en     = bus.port_we & ~full_w;
    assign baud_done = (baud == BAUD_LAST);

    always_comb begin
        state_n = state;
        baud_n  = baud;
        bit_n   = bit_cnt;
        shift_n = shift;
        tx_n    = tx_r;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                tx_n = 1'b1;
                if (!empty_w) begin
                    pop     = 1'b1;
                    state_n = S_START;
                    baud_n  = '0;
                    shift_n = mem[rd_ptr];
                    tx_n    = 1'b0;
                end
            end
            S_START: begin
                if (baud_done) begin
                    state_n = S_DATA;
                    baud_n  = '0;
                    bit_n   = 3'd0;
                    tx_n    = shift[0];
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_n = '0;
                    if (bit_cnt == 3'd7) begin
                        state_n = S_STOP;
                        tx_n    = 1'b1;
                    end else begin
                        // tx is registered, so it takes the bit that the shift is about to expose
                        bit_n   = bit_cnt + 3'd1;
                        shift_n = {1'b0, shift[7:1]};
                        tx_n    = shift[1];
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    baud_n = '0;
                    if (!empty_w) begin
                        pop     = 1'b1;
                        state_n = S_START;
                        shift_n = mem[rd_ptr];
                        tx_n    = 1'b0;
                    end else begin
                        state_n = S_IDLE;
                        tx_n    = 1'b1;
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_cnt <= 3'd0;
            shift   <= 8'd0;
            tx_r    <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_cnt <= bit_n;
            shift   <= shift_n;
            tx_r    <= tx_n;
        end
    end

    // Storage needs no reset: entries are only read once count says they are valid.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= bus.port_out;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
            if (bus.port_we && full_w) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign bus.tx       = tx_r;
    assign bus.busy     = (state != S_IDLE) | ~empty_w;
    assign bus.full     = full_w;
    assign bus.empty    = empty_w;
    assign bus.count    = count_r;
    assign bus.overflow = overflow_r;
    assign dbg_state    = state;
endmodule

// File: tb/tb_port_out_uart_tx.sv
// Directed + random bench for port_out_uart_tx against a frame-timeline reference model.
module tb_port_out_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;

  port_out_uart_tx_if #(.DEPTH(DEPTH)) bus ();

  port_out_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: per accepted byte, the edge it was written and the edge its frame starts.
  int         w_q[$];
  int         p_q[$];
  logic [7:0] exp_q[$];
  logic       ovf_m = 1'b0;

  function automatic int count_at(input int e);
    int n;
    n = 0;
    foreach (w_q[i]) begin
      if (w_q[i] <= e) n++;
      if (p_q[i] <= e) n--;
    end
    return n;
  endfunction

  function automatic logic in_frame(input int e);
    foreach (p_q[i]) begin
      if (e >= p_q[i] && e < p_q[i] + FRAME) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic tx_at(input int e);
    int o;
    logic [7:0] b;
    foreach (p_q[i]) begin
      if (e >= p_q[i] && e < p_q[i] + FRAME) begin
        o = (e - p_q[i]) / CPB;
        if (o == 0) return 1'b0;
        if (o == 9) return 1'b1;
        b = exp_q[i];
        return b[o-1];
      end
    end
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = count_at(cyc);
    chk("tx",       {7'd0, bus.tx},       {7'd0, tx_at(cyc)});
    chk("busy",     {7'd0, bus.busy},     {7'd0, (in_frame(cyc) || n > 0)});
    chk("full",     {7'd0, bus.full},     {7'd0, (n == DEPTH)});
    chk("empty",    {7'd0, bus.empty},    {7'd0, (n == 0)});
    chk("count",    {5'd0, bus.count},    8'(n));
    chk("overflow", {7'd0, bus.overflow}, {7'd0, ovf_m});
  endtask

  // Called at posedge+1; applies inputs for the next edge, then checks after it.
  task automatic step(input logic we, input logic [7:0] d);
    int p;
    bus.port_we  = we;
    bus.port_out = d;
    @(posedge clock);
    cyc++;
    if (we) begin
      if (count_at(cyc - 1) == DEPTH) begin
        ovf_m = 1'b1;
      end else begin
        p = cyc + 1;
        if (p_q.size() > 0 && p_q[$] + FRAME > p) p = p_q[$] + FRAME;
        w_q.push_back(cyc);
        p_q.push_back(p);
        exp_q.push_back(d);
      end
    end
    #1;
    bus.port_we = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'($urandom));
  endtask

  task automatic apply_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_tx",    {7'd0, bus.tx},       8'd1);
    chk("rst_busy",  {7'd0, bus.busy},     8'd0);
    chk("rst_empty", {7'd0, bus.empty},    8'd1);
    chk("rst_full",  {7'd0, bus.full},     8'd0);
    chk("rst_count", {5'd0, bus.count},    8'd0);
    chk("rst_ovf",   {7'd0, bus.overflow}, 8'd0);
    chk("rst_state", {6'd0, dbg_state},    8'd0);
    w_q.delete();
    p_q.delete();
    exp_q.delete();
    ovf_m = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    cyc++;
    #1;
    check_outputs();
  endtask

  initial begin
    int target;
    bus.port_we  = 1'b0;
    bus.port_out = 8'd0;

    // Power-on reset
    apply_reset();

    // Single frame of 0x0A
    step(1'b1, 8'h0A);
    idle(FRAME + 5);

    // Back-to-back writes: the first is popped, so occupancy peaks at 3
    step(1'b1, 8'h55);
    step(1'b1, 8'hAA);
    step(1'b1, 8'hFF);
    step(1'b1, 8'h00);
    chk("b2b_peak", {5'd0, bus.count}, 8'd3);
    idle(4 * FRAME + 5);

    // Fill during a frame: 6th byte is dropped and overflow sticks
    step(1'b1, 8'($urandom));
    idle(5);
    repeat (5) step(1'b1, 8'($urandom));
    chk("ovf_full", {7'd0, bus.full},     8'd1);
    chk("ovf_set",  {7'd0, bus.overflow}, 8'd1);
    idle(5 * FRAME + 5);
    chk("ovf_held", {7'd0, bus.overflow}, 8'd1);

    // Write to a full FIFO on the same edge as the STOP->START pop
    apply_reset();
    step(1'b1, 8'($urandom));
    repeat (4) step(1'b1, 8'($urandom));
    chk("pf_full", {7'd0, bus.full}, 8'd1);
    target = p_q[0] + FRAME;
    while (cyc < target - 1) step(1'b0, 8'd0);
    step(1'b1, 8'hEE);
    chk("pf_count", {5'd0, bus.count},    8'(DEPTH - 1));
    chk("pf_ovf",   {7'd0, bus.overflow}, 8'd1);
    idle(4 * FRAME + 5);

    // Pointer wrap at a rate the transmitter can sustain
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(i));
      chk("wrap_le2", {7'd0, (bus.count <= 2)}, 8'd1);
      repeat ($urandom_range(FRAME - 1, FRAME + 6)) begin
        step(1'b0, 8'd0);
        chk("wrap_le2", {7'd0, (bus.count <= 2)}, 8'd1);
      end
    end
    idle(FRAME + 5);

    // Random traffic, including overruns
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 9) == 0), 8'($urandom));
    end
    idle((DEPTH + 1) * FRAME + 5);

    // Asynchronous reset in the middle of the 0xC3 data bits, then a clean 0x81 frame
    step(1'b1, 8'hC3);
    idle(20);
    apply_reset();
    step(1'b1, 8'h81);
    idle(FRAME + 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/port_out_uart_tx.md
Name: port_out_uart_tx

Overview:
Output-port serializer that sits directly downstream of the cpu's 8-bit port_out.
- Captures each byte the cpu writes to its output port into a small FIFO.
- Transmits the queued bytes as 8N1 asynchronous serial frames on a single tx line.
- Decouples cpu write bursts from the slow serial rate and exposes status for polling through the cpu's input port.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit (≥2)
DEPTH, 4, FIFO entries (power of two, ≥2)

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset (reset=0 asserts)
port_out  input  8  byte from cpu output port
port_we  input  1  write strobe, 1 cycle per byte
tx  output  1  serial line, idle high
busy  output  1  FIFO not empty or frame in progress
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries
count  output  $clog2(DEPTH)+1  FIFO occupancy
overflow  output  1  sticky: write attempted while full

Behaviour:
- Reset (reset=0, async): FIFO pointers and count = 0, state = IDLE, tx = 1, busy = 0, full = 0, empty = 1, overflow = 0.
  - Mid-frame reset aborts the frame; tx returns to 1 immediately.
- FIFO write: on a rising edge with port_we=1 and full=0, store port_out and increment count.
  - port_we=1 while full=0 is false: byte dropped, overflow set to 1 and held until reset.
  - full is evaluated before the edge, so a write to a full FIFO in the same cycle as a pop is still dropped.
- FIFO pop: happens on entry to START.
  - Write and pop in the same cycle: count unchanged, both take effect.
  - Write into an empty FIFO: that byte cannot be popped in the same cycle.
- Pointers wrap modulo DEPTH. count spans 0..DEPTH.
- FSM states: IDLE, START, DATA, STOP. Bit counter 0..7; baud counter 0..CLKS_PER_BIT-1.
  - IDLE: tx = 1. If empty=0, pop the head into shift register and go to START.
  - START: tx = 0 for CLKS_PER_BIT cycles, then DATA with bit counter = 0.
  - DATA: tx = shift[0] (LSB first), each bit held CLKS_PER_BIT cycles, then shift right. After bit 7 completes, go to STOP.
  - STOP: tx = 1 for CLKS_PER_BIT cycles. Then, if empty=0, pop and go straight to START with no idle gap; otherwise go to IDLE.
- tx is registered and glitch-free.
- Latency: a write accepted at edge N gives tx = 0 after edge N+1 (one IDLE evaluation cycle).
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- busy = (state != IDLE) or (empty = 0). full, empty and count are derived from registered count.

Test Plan:
- CLKS_PER_BIT=4, reset released, single write 0x0A -> tx low 4 cycles, then bits 0,1,0,1,0,0,0,0 each 4 cycles, then high 4 cycles; 40 cycles total; busy falls after stop bit; overflow=0.
- Back-to-back writes 0x55, 0xAA, 0xFF, 0x00 on consecutive cycles -> count peaks at 3 (first popped); four frames with no idle cycles between stop and next start bit; decoded bytes match in order.
- 5 writes while the first frame is in progress (DEPTH=4) -> FIFO fills; 6th write dropped, overflow=1 and held; full=1 until next pop; transmitted sequence excludes the dropped byte.
- Write while full=1 in the same cycle the FSM pops (STOP→START) -> write dropped, count goes DEPTH→DEPTH-1, overflow=1.
- Pointer wrap: 10 bytes 0x00..0x09 written at a rate never exceeding drain -> all 10 transmitted in order; count never exceeds 2.
- reset=0 asserted mid-DATA of 0xC3 -> tx=1, busy=0, empty=1, count=0 immediately (asynchronously); after release, new write 0x81 transmits a clean full frame.
